pos_remote_tx_buffer: RTL and testbench
=======================================

// Module: pos_remote_tx_buffer
// PURPOSE
//  Buffers position (offset) packets that the position input ring ejects toward remote FPGA nodes.
//  Fans each packet out as one flit per remote destination with non-zero lifetime to the inter-FPGA TX port.
//  Drives remote_buffer_back_pressure back into the ring. Sits between the ring's remote output and the network packer.
// PARAMETERS
//  DEPTH         16                       FIFO entries (power of 2, >=4)
//  AFULL_THRESH  DEPTH-4                  occupancy at/above which back pressure asserts
//  NUM_DEST      NUM_REMOTE_DEST_NODES    remote destinations per packet (MD_pkg)
// PORTS
//  clk                          in   1                        system clock
//  rst                          in   1                        async reset, active-low
//  local_node_id                in   NODE_ID_WIDTH            stamped into every flit
//  in_offset_pkt                in   OFFSET_PKT_STRUCT_WIDTH  packet from ring
//  in_gcid                      in   3*GLOBAL_CELL_ID_WIDTH   global cell id of packet
//  in_lifetime                  in   NUM_DEST*NB_CELL_COUNT_WIDTH  per-dest lifetime, dest d at slice d
//  in_valid                     in   1                        push strobe (no ready; ring honours back pressure)
//  remote_buffer_back_pressure  out  1                        count >= AFULL_THRESH
//  tx_offset_pkt/tx_gcid        out  as inputs                head entry payload
//  tx_node_id                   out  NODE_ID_WIDTH            local_node_id
//  tx_dest_idx                  out  $clog2(NUM_DEST)         destination slot of current flit
//  tx_lifetime                  out  NB_CELL_COUNT_WIDTH      lifetime for that destination
//  tx_valid / tx_ready          out / in  1                   valid/ready handshake to network packer
//  buffer_empty                 out  1                        FIFO empty and no flit pending
//  stat_flits / stat_overflow   out  32 / 1                   statistics (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0 except buffer_empty=1; FIFO pointers, count, FSM cleared; an in-flight flit is discarded.
//  Push: in_valid && count<DEPTH -> entry written. Full is judged on pre-pop count; a push when full is dropped.
//  Same-cycle push+pop at count==DEPTH: pop happens, push dropped. Otherwise count = count + push - pop.
//  back pressure: registered from next count; asserts the cycle after count reaches AFULL_THRESH.
//  FSM IDLE: FIFO non-empty -> scan head lifetimes for the lowest d with lifetime!=0.
//    Found -> SEND with tx_dest_idx=d, tx_valid=1 (registered; earliest one cycle after push).
//    All-zero -> pop head, emit no flit, stay IDLE (one cycle per dropped entry).
//  FSM SEND: tx_valid held and all tx_* stable until tx_valid&&tx_ready.
//    On handshake: next nonzero d'>d exists -> present it next cycle.
//    None -> pop head; the next head, if any, is presented the following cycle. No zero-bubble chaining required.
//  Per-dest order follows increasing d. Entries leave in FIFO order. Pointers wrap modulo DEPTH.
//  tx_ready while tx_valid=0 is ignored. tx_valid never drops without a handshake (except reset).
//  Lifetime values pass through unmodified; width NB_CELL_COUNT_WIDTH, no arithmetic.
// CONFIGURATION
//  POS_TX_STATS_EN defined:
//    stat_flits = wrapping 32-bit count of completed handshakes.
//    stat_overflow = sticky flag set by any dropped push. Both cleared only by reset.
//  Undefined: stat_flits=0 and stat_overflow=0 constant; no counter logic; ports retained.
// STRUCTURE
//  MD_pkg: pos_tx_entry_t {offset_pkt, gcid, lifetime[NUM_DEST]}, widths, NUM_REMOTE_DEST_NODES.
//  Sub-module pos_tx_fifo: generic sync FIFO (push/pop/count/full/empty, async active-low rst).
//  Top holds the dest-scan FSM and the stats.
// TESTING
//  1 reset: rst=0 mid-SEND with tx_valid=1 -> next cycle tx_valid=0, buffer_empty=1, back pressure=0.
//  2 single pkt, lifetimes {d0=3,d1=0,d2=5}, tx_ready=1 -> flits d0(lt3), d2(lt5); pop; buffer_empty=1.
//  3 all-zero lifetimes pushed -> no tx_valid ever; entry popped within 2 cycles.
//  4 tx_ready=0 for 10 cycles -> tx_* stable every cycle; then ready=1 -> exactly one handshake per flit.
//  5 DEPTH=16, ready=0, 13 pushes -> back pressure after 12th push; 17 pushes -> 17th dropped, stat_overflow=1 (STATS_EN).
//  6 ordering: push pkts A,B,C at full rate with random ready -> flits emitted A*,B*,C* in order; stat_flits equals the total.

Source files
------------

// File: rtl/MD_pkg.sv
// Shared widths, entry layout and destination-scan helper for the remote
// position TX buffer.
package MD_pkg;

  localparam int NUM_REMOTE_DEST_NODES   = 3;
  localparam int NODE_ID_WIDTH           = 4;
  localparam int OFFSET_PKT_STRUCT_WIDTH = 24;
  localparam int GLOBAL_CELL_ID_WIDTH    = 3;
  localparam int NB_CELL_COUNT_WIDTH     = 4;
  localparam int DEST_IDX_WIDTH          = (NUM_REMOTE_DEST_NODES > 1) ?
                                           $clog2(NUM_REMOTE_DEST_NODES) : 1;

  // Destination d lives in element d (bits d*W +: W of the flat port).
  typedef logic [NUM_REMOTE_DEST_NODES-1:0][NB_CELL_COUNT_WIDTH-1:0] lifetime_arr_t;

  typedef struct packed {
    logic [OFFSET_PKT_STRUCT_WIDTH-1:0] offset_pkt;
    logic [3*GLOBAL_CELL_ID_WIDTH-1:0]  gcid;
    lifetime_arr_t                      lifetime;
  } pos_tx_entry_t;

  localparam int ENTRY_WIDTH = $bits(pos_tx_entry_t);

  typedef struct packed {
    logic                      found;
    logic [DEST_IDX_WIDTH-1:0] idx;
  } dest_sel_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

  // Lowest destination index >= first whose lifetime is non-zero.
  function automatic dest_sel_t find_dest(input lifetime_arr_t lt, input int first);
    dest_sel_t sel;
    sel = '0;
    for (int d = NUM_REMOTE_DEST_NODES - 1; d >= 0; d--) begin
      if ((d >= first) && (lt[d] != '0)) begin
        sel.found = 1'b1;
        sel.idx   = DEST_IDX_WIDTH'(d);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/pos_tx_fifo.sv
// Generic synchronous FIFO. A push while full is dropped even if a pop
// happens in the same cycle; count_next is exposed so the owner can register
// flags from it without an extra cycle of lag.
module pos_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [$clog2(DEPTH):0]   o_count_next,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full       = (r_count == CW'(DEPTH));
  assign o_empty      = (r_count == '0);
  assign w_push_ok    = i_push && !o_full;
  assign w_pop_ok     = i_pop && !o_empty;
  assign o_count      = r_count;
  assign o_count_next = r_count + CW'(w_push_ok) - CW'(w_pop_ok);
  assign o_rd_data    = r_mem[r_rd_ptr];

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= o_count_next;
    end
  end

endmodule

// File: rtl/pos_remote_tx_buffer.sv
// Remote position TX buffer: queues offset packets from the ring and fans
// each out as one flit per destination with a non-zero lifetime.
// Optional statistics counters are built when POS_TX_STATS_EN is defined;
// otherwise stat_flits/stat_overflow are tied to zero.
//
// state   | meaning
// IDLE    | no flit offered; scan head entry or drop it if all lifetimes zero
// SEND    | flit for r_dest_idx offered, held until tx_ready
module pos_remote_tx_buffer
  import MD_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 4
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [NODE_ID_WIDTH-1:0]                              local_node_id,
  input  logic [OFFSET_PKT_STRUCT_WIDTH-1:0]                    in_offset_pkt,
  input  logic [3*GLOBAL_CELL_ID_WIDTH-1:0]                     in_gcid,
  input  logic [NUM_REMOTE_DEST_NODES*NB_CELL_COUNT_WIDTH-1:0]  in_lifetime,
  input  logic                                                  in_valid,
  output logic                                                  remote_buffer_back_pressure,
  output logic [OFFSET_PKT_STRUCT_WIDTH-1:0]                    tx_offset_pkt,
  output logic [3*GLOBAL_CELL_ID_WIDTH-1:0]                     tx_gcid,
  output logic [NODE_ID_WIDTH-1:0]                              tx_node_id,
  output logic [DEST_IDX_WIDTH-1:0]                             tx_dest_idx,
  output logic [NB_CELL_COUNT_WIDTH-1:0]                        tx_lifetime,
  output logic                                                  tx_valid,
  input  logic                                                  tx_ready,
  output logic                                                  buffer_empty,
  output logic [31:0]                                           stat_flits,
  output logic                                                  stat_overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  pos_tx_entry_t             w_in_entry;
  pos_tx_entry_t             w_head;
  logic [CW-1:0]             w_count;
  logic [CW-1:0]             w_count_next;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_pop;
  logic                      w_unused;

  tx_state_t                 r_state;
  tx_state_t                 w_state_next;
  logic [DEST_IDX_WIDTH-1:0] r_dest_idx;
  logic [DEST_IDX_WIDTH-1:0] w_dest_next;
  dest_sel_t                 w_first_sel;
  dest_sel_t                 w_next_sel;
  logic                      r_bp;

  // Pack the ring-side fields into one FIFO entry.
  always_comb begin
    w_in_entry            = '0;
    w_in_entry.offset_pkt = in_offset_pkt;
    w_in_entry.gcid       = in_gcid;
    w_in_entry.lifetime   = lifetime_arr_t'(in_lifetime);
  end

  pos_tx_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (in_valid),
    .i_wr_data    (w_in_entry),
    .i_pop        (w_pop),
    .o_rd_data    (w_head),
    .o_count      (w_count),
    .o_count_next (w_count_next),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  // State and destination-slot registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_dest_idx <= '0;
    end else begin
      r_state    <= w_state_next;
      r_dest_idx <= w_dest_next;
    end
  end

  // Next-state: pick first live destination, advance on handshake, pop when done.
  always_comb begin
    w_state_next = r_state;
    w_dest_next  = r_dest_idx;
    w_pop        = 1'b0;
    w_first_sel  = find_dest(w_head.lifetime, 0);
    w_next_sel   = find_dest(w_head.lifetime, int'(r_dest_idx) + 1);
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          if (w_first_sel.found) begin
            w_state_next = ST_SEND;
            w_dest_next  = w_first_sel.idx;
          end else begin
            w_pop = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (w_next_sel.found) begin
            w_dest_next = w_next_sel.idx;
          end else begin
            w_pop        = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Back pressure follows the post-update occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bp <= 1'b0;
    end else begin
      r_bp <= (w_count_next >= CW'(AFULL_THRESH));
    end
  end

  // Head stays put while in SEND, so payload fields are stable until handshake.
  assign tx_valid                    = (r_state == ST_SEND);
  assign tx_offset_pkt               = tx_valid ? w_head.offset_pkt : '0;
  assign tx_gcid                     = tx_valid ? w_head.gcid : '0;
  assign tx_node_id                  = tx_valid ? local_node_id : '0;
  assign tx_dest_idx                 = tx_valid ? r_dest_idx : '0;
  assign tx_lifetime                 = tx_valid ? w_head.lifetime[r_dest_idx] : '0;
  assign buffer_empty                = w_empty && !tx_valid;
  assign remote_buffer_back_pressure = r_bp;

`ifdef POS_TX_STATS_EN
  logic [31:0] r_stat_flits;
  logic        r_stat_overflow;

  // Wrapping handshake count and sticky dropped-push flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_flits    <= '0;
      r_stat_overflow <= 1'b0;
    end else begin
      if (tx_valid && tx_ready) r_stat_flits <= r_stat_flits + 32'd1;
      if (in_valid && w_full)   r_stat_overflow <= 1'b1;
    end
  end

  assign stat_flits    = r_stat_flits;
  assign stat_overflow = r_stat_overflow;
  assign w_unused      = ^w_count;
`else
  assign stat_flits    = '0;
  assign stat_overflow = 1'b0;
  assign w_unused      = ^{w_count, w_full};
`endif

endmodule

// File: tb/tb_pos_remote_tx_buffer.sv
// Bench for pos_remote_tx_buffer: expected flits are queued when packets are
// driven and checked in order whenever a handshake occurs.
module tb_pos_remote_tx_buffer;
  import MD_pkg::*;

  localparam int NB = NB_CELL_COUNT_WIDTH;
  localparam int LW = NUM_REMOTE_DEST_NODES * NB;
`ifdef POS_TX_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic                                    clk;
  logic                                    rst;
  logic [NODE_ID_WIDTH-1:0]                local_node_id;
  logic [OFFSET_PKT_STRUCT_WIDTH-1:0]      in_offset_pkt;
  logic [3*GLOBAL_CELL_ID_WIDTH-1:0]       in_gcid;
  logic [LW-1:0]                           in_lifetime;
  logic                                    in_valid;
  logic                                    remote_buffer_back_pressure;
  logic [OFFSET_PKT_STRUCT_WIDTH-1:0]      tx_offset_pkt;
  logic [3*GLOBAL_CELL_ID_WIDTH-1:0]       tx_gcid;
  logic [NODE_ID_WIDTH-1:0]                tx_node_id;
  logic [DEST_IDX_WIDTH-1:0]               tx_dest_idx;
  logic [NB-1:0]                           tx_lifetime;
  logic                                    tx_valid;
  logic                                    tx_ready;
  logic                                    buffer_empty;
  logic [31:0]                             stat_flits;
  logic                                    stat_overflow;

  typedef struct {
    logic [OFFSET_PKT_STRUCT_WIDTH-1:0] off;
    logic [3*GLOBAL_CELL_ID_WIDTH-1:0]  gcid;
    logic [DEST_IDX_WIDTH-1:0]          d;
    logic [NB-1:0]                      lt;
  } exp_flit_t;

  localparam logic [NODE_ID_WIDTH-1:0] NODE_ID = 4'h9;

  exp_flit_t sb[$];
  exp_flit_t mon_e;
  int checks      = 0;
  int errors      = 0;
  int hs_count    = 0;
  int n_exp_flits = 0;
  bit prev_hold   = 1'b0;

  pos_remote_tx_buffer #(.DEPTH(16), .AFULL_THRESH(12)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .local_node_id               (local_node_id),
    .in_offset_pkt               (in_offset_pkt),
    .in_gcid                     (in_gcid),
    .in_lifetime                 (in_lifetime),
    .in_valid                    (in_valid),
    .remote_buffer_back_pressure (remote_buffer_back_pressure),
    .tx_offset_pkt               (tx_offset_pkt),
    .tx_gcid                     (tx_gcid),
    .tx_node_id                  (tx_node_id),
    .tx_dest_idx                 (tx_dest_idx),
    .tx_lifetime                 (tx_lifetime),
    .tx_valid                    (tx_valid),
    .tx_ready                    (tx_ready),
    .buffer_empty                (buffer_empty),
    .stat_flits                  (stat_flits),
    .stat_overflow               (stat_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard consumer: every handshake must match the oldest expected flit.
  always @(negedge clk) begin
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        checks++;
        if (tx_valid !== 1'b1) begin
          errors++;
          $display("FAIL valid_hold: tx_valid=%b required 1 (dropped without handshake)", tx_valid);
        end
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        hs_count++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_flit: got d=%0d lt=%0d off=%h, required no flit",
                   tx_dest_idx, tx_lifetime, tx_offset_pkt);
        end else begin
          mon_e = sb.pop_front();
          if (tx_dest_idx !== mon_e.d || tx_lifetime !== mon_e.lt || tx_offset_pkt !== mon_e.off ||
              tx_gcid !== mon_e.gcid || tx_node_id !== NODE_ID) begin
            errors++;
            $display("FAIL flit: got d=%0d lt=%0d off=%h gcid=%h node=%h, required d=%0d lt=%0d off=%h gcid=%h node=%h",
                     tx_dest_idx, tx_lifetime, tx_offset_pkt, tx_gcid, tx_node_id,
                     mon_e.d, mon_e.lt, mon_e.off, mon_e.gcid, NODE_ID);
          end
        end
      end
      prev_hold = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
    end
  end

  // Drive one packet for a single cycle; queue its expected flits unless it is
  // meant to be dropped or discarded.
  task automatic push_pkt(input logic [OFFSET_PKT_STRUCT_WIDTH-1:0] off,
                          input logic [3*GLOBAL_CELL_ID_WIDTH-1:0] gcid,
                          input logic [LW-1:0] lts, input bit no_expect);
    exp_flit_t e;
    in_offset_pkt = off;
    in_gcid       = gcid;
    in_lifetime   = lts;
    in_valid      = 1'b1;
    if (!no_expect) begin
      for (int d = 0; d < NUM_REMOTE_DEST_NODES; d++) begin
        if (lts[d*NB +: NB] != '0) begin
          e.off  = off;
          e.gcid = gcid;
          e.d    = DEST_IDX_WIDTH'(d);
          e.lt   = lts[d*NB +: NB];
          sb.push_back(e);
          n_exp_flits++;
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((sb.size() != 0 || buffer_empty !== 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || buffer_empty !== 1'b1) begin
      errors++;
      $display("FAIL %s_drain: pending=%0d buffer_empty=%b, required pending=0 buffer_empty=1",
               name, sb.size(), buffer_empty);
    end
  endtask

  task automatic test_reset();
    int n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || buffer_empty !== 1'b1 || remote_buffer_back_pressure !== 1'b0 ||
        tx_dest_idx !== '0 || tx_lifetime !== '0 || stat_flits !== 32'd0 || stat_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: valid=%b empty=%b bp=%b d=%0d lt=%0d flits=%0d ovf=%b, required 0 1 0 0 0 0 0",
               tx_valid, buffer_empty, remote_buffer_back_pressure, tx_dest_idx, tx_lifetime,
               stat_flits, stat_overflow);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    tx_ready = 1'b0;
    push_pkt(24'h0000AA, 9'h011, {4'd0, 4'd0, 4'd4}, 1'b1);
    while (tx_valid !== 1'b1 && n < 5) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_presend: tx_valid=%b required 1", tx_valid);
    end
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || buffer_empty !== 1'b1 || remote_buffer_back_pressure !== 1'b0) begin
      errors++;
      $display("FAIL reset_midsend: valid=%b empty=%b bp=%b, required 0 1 0",
               tx_valid, buffer_empty, remote_buffer_back_pressure);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    n_exp_flits = 0;
  endtask

  task automatic test_single();
    int hs0;
    tx_ready = 1'b1;
    hs0 = hs_count;
    push_pkt(24'h123456, 9'h1A5, {4'd5, 4'd0, 4'd3}, 1'b0);
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || buffer_empty !== 1'b0) begin
      errors++;
      $display("FAIL single_latency0: valid=%b empty=%b, required 0 0", tx_valid, buffer_empty);
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_dest_idx !== 2'd0 || tx_lifetime !== 4'd3) begin
      errors++;
      $display("FAIL single_first: valid=%b d=%0d lt=%0d, required 1 0 3", tx_valid, tx_dest_idx, tx_lifetime);
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_dest_idx !== 2'd2 || tx_lifetime !== 4'd5) begin
      errors++;
      $display("FAIL single_second: valid=%b d=%0d lt=%0d, required 1 2 5", tx_valid, tx_dest_idx, tx_lifetime);
    end
    @(negedge clk);
    checks++;
    if (buffer_empty !== 1'b1 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_empty: empty=%b valid=%b, required 1 0", buffer_empty, tx_valid);
    end
    wait_drain("single", 20);
    checks++;
    if (hs_count - hs0 != 2) begin
      errors++;
      $display("FAIL single_count: handshakes=%0d required 2", hs_count - hs0);
    end
  endtask

  task automatic test_all_zero();
    tx_ready = 1'b1;
    push_pkt(24'h00BEEF, 9'h042, {4'd0, 4'd0, 4'd0}, 1'b0);
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_novalid: tx_valid=%b required 0", tx_valid);
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || buffer_empty !== 1'b1) begin
      errors++;
      $display("FAIL zero_popped: valid=%b empty=%b, required 0 1", tx_valid, buffer_empty);
    end
    push_pkt(24'h00C0DE, 9'h043, {4'd6, 4'd0, 4'd0}, 1'b0);
    wait_drain("zero", 20);
  endtask

  task automatic test_stall();
    int hs0;
    int n = 0;
    tx_ready = 1'b0;
    push_pkt(24'h00ABCD, 9'h155, {4'd0, 4'd7, 4'd2}, 1'b0);
    while (tx_valid !== 1'b1 && n < 5) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_dest_idx !== 2'd0 || tx_lifetime !== 4'd2 ||
          tx_offset_pkt !== 24'h00ABCD || tx_gcid !== 9'h155 || tx_node_id !== NODE_ID) begin
        errors++;
        $display("FAIL stall_stable: cycle=%0d valid=%b d=%0d lt=%0d off=%h gcid=%h, required 1 0 2 00abcd 155",
                 c, tx_valid, tx_dest_idx, tx_lifetime, tx_offset_pkt, tx_gcid);
      end
    end
    hs0 = hs_count;
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_drain("stall", 20);
    checks++;
    if (hs_count - hs0 != 2) begin
      errors++;
      $display("FAIL stall_count: handshakes=%0d required 2", hs_count - hs0);
    end
  endtask

  task automatic test_backpressure();
    int hs0;
    int exp_hs;
    tx_ready = 1'b0;
    hs0 = hs_count;
    for (int i = 1; i <= 16; i++) begin
      push_pkt(24'(i), 9'(i), {4'hC, 4'd0, 4'(i)}, 1'b0);
      @(negedge clk);
      checks++;
      if (remote_buffer_back_pressure !== (i >= 12)) begin
        errors++;
        $display("FAIL bp_push%0d: bp=%b required %b", i, remote_buffer_back_pressure, (i >= 12));
      end
    end
    checks++;
    if (stat_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_before: stat_overflow=%b required 0", stat_overflow);
    end
    push_pkt(24'h0000FF, 9'h1FF, {4'd1, 4'd1, 4'd1}, 1'b1);
    @(negedge clk);
    checks++;
    if (stat_overflow !== STATS_ON || remote_buffer_back_pressure !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after: stat_overflow=%b bp=%b, required %b 1",
               stat_overflow, remote_buffer_back_pressure, STATS_ON);
    end
    exp_hs = sb.size();
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_drain("bp", 300);
    checks++;
    if (hs_count - hs0 != exp_hs || remote_buffer_back_pressure !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: handshakes=%0d bp=%b, required %0d 0",
               hs_count - hs0, remote_buffer_back_pressure, exp_hs);
    end
  endtask

  task automatic test_ordering();
    int hs0;
    int exp_hs;
    hs0 = hs_count;
    exp_hs = sb.size();
    fork
      begin
        for (int p = 0; p < 6; p++) begin
          logic [LW-1:0] lts;
          lts = LW'($urandom_range(0, (1 << LW) - 1));
          for (int d = 0; d < NUM_REMOTE_DEST_NODES; d++) begin
            if (lts[d*NB +: NB] != '0) exp_hs++;
          end
          push_pkt(24'hA00000 + 24'(p), 9'(p * 37), lts, 1'b0);
        end
      end
      begin
        repeat (40) begin
          @(posedge clk); #1;
          tx_ready = 1'($urandom_range(0, 1));
        end
        tx_ready = 1'b1;
      end
    join
    wait_drain("order", 200);
    checks++;
    if (hs_count - hs0 != exp_hs) begin
      errors++;
      $display("FAIL order_count: handshakes=%0d required %0d", hs_count - hs0, exp_hs);
    end
    checks++;
    if (stat_flits !== (STATS_ON ? 32'(n_exp_flits) : 32'd0)) begin
      errors++;
      $display("FAIL stat_flits: got %0d required %0d", stat_flits,
               STATS_ON ? n_exp_flits : 0);
    end
  endtask

  initial begin
    rst           = 1'b0;
    local_node_id = NODE_ID;
    in_offset_pkt = '0;
    in_gcid       = '0;
    in_lifetime   = '0;
    in_valid      = 1'b0;
    tx_ready      = 1'b0;
    test_reset();
    test_single();
    test_all_zero();
    test_stall();
    test_backpressure();
    test_ordering();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
